// File: rtl/wrr_grant_collector_pkg.sv
// Shared constants, types and grant-integrity helpers for the WRR grant collector.
package wrr_pkg;

  localparam int N_REQ = 32;
  localparam int ID_W  = $clog2(N_REQ);

  typedef logic [ID_W-1:0] wrr_id_t;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} wrr_col_state_e;

  // True when exactly one requester bit is set.
  function automatic logic f_is_onehot(input logic [N_REQ-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt += int'(v[i]);
    end
    return (cnt == 1);
  endfunction

  // Encoded index of the set bit; only meaningful for one-hot input.
  function automatic wrr_id_t f_index(input logic [N_REQ-1:0] v);
    wrr_id_t idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) begin
        idx = wrr_id_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_grant_collector_if.sv
// Grant/ack handshake from the arbiter plus the valid/ready drain to the consumer.
interface wrr_grant_collector_if;
  import wrr_pkg::*;

  logic [N_REQ-1:0] gnt_w;
  wrr_id_t          gnt_id;
  logic             ack;
  logic             out_valid;
  logic             out_ready;
  wrr_id_t          out_id;

  modport master (
    output gnt_w, gnt_id, out_ready,
    input  ack, out_valid, out_id
  );

  modport slave (
    input  gnt_w, gnt_id, out_ready,
    output ack, out_valid, out_id
  );

endinterface

// File: rtl/wrr_grant_collector_fifo.sv
// First-word fall-through FIFO for accepted grant IDs; push while full is legal
// only when a pop happens in the same cycle.
module wrr_grant_fifo
  import wrr_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wrr_id_t,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  T              i_push_data,
  input  logic          i_pop,
  output T              o_head,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;
  logic          w_full;

  assign w_pop  = i_pop && (r_level != '0);
  assign w_full = (r_level == LW'(DEPTH));
  assign w_push = i_push && (!w_full || w_pop);

  // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/wrr_grant_collector.sv
// Acknowledges arbiter grants, checks their integrity, counts good ones and
// queues their IDs for the downstream consumer.
module wrr_grant_collector
  import wrr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wrr_grant_collector_if.slave     bus,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic [CNT_W-1:0]         o_grant_cnt,
  output logic                     o_err_onehot,
  output logic                     o_err_id_mis
);

  localparam int LW = $clog2(DEPTH) + 1;

  wrr_col_state_e r_state;
  logic           r_ack;
  logic [CNT_W-1:0] r_grant_cnt;
  logic           r_err_onehot;
  logic           r_err_id_mis;

  logic           w_offer;
  logic           w_onehot;
  logic           w_id_ok;
  logic           w_pop;
  logic           w_accept;
  logic           w_capture;
  logic           w_push;
  logic           w_full;
  logic           w_empty;
  wrr_id_t        w_head;
  logic [LW-1:0]  w_level;

  assign w_offer   = (bus.gnt_w != '0);
  assign w_onehot  = f_is_onehot(bus.gnt_w);
  assign w_id_ok   = w_onehot && (f_index(bus.gnt_w) == bus.gnt_id);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_pop     = !w_empty && bus.out_ready;
  assign w_accept  = !w_full || w_pop;
  assign w_capture = (r_state == IDLE) && w_offer && w_accept;
  assign w_push    = w_capture && w_id_ok;

  wrr_grant_fifo #(
    .DEPTH (DEPTH),
    .T     (wrr_id_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (bus.gnt_id),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Capture/ack FSM with registered ack, grant counter and sticky integrity flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ack        <= 1'b0;
      r_grant_cnt  <= '0;
      r_err_onehot <= 1'b0;
      r_err_id_mis <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            if (w_id_ok) begin
              r_grant_cnt <= r_grant_cnt + 1'b1;
            end else if (!w_onehot) begin
              r_err_onehot <= 1'b1;
            end else begin
              r_err_id_mis <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.out_valid = !w_empty;
  assign bus.out_id    = w_head;
  assign o_fifo_level  = w_level;
  assign o_grant_cnt   = r_grant_cnt;
  assign o_err_onehot  = r_err_onehot;
  assign o_err_id_mis  = r_err_id_mis;

endmodule

// File: tb/tb_wrr_grant_collector.sv
// Randomized and directed bench for wrr_grant_collector with a queue-based
// reference model and a scoreboard monitor on the consumer side.
module tb_wrr_grant_collector;
  import wrr_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0]       grant_cnt;
  logic                   err_onehot;
  logic                   err_id_mis;

  wrr_grant_collector_if bus ();

  wrr_grant_collector #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .o_fifo_level (fifo_level),
    .o_grant_cnt  (grant_cnt),
    .o_err_onehot (err_onehot),
    .o_err_id_mis (err_id_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of IDs the consumer should see, plus expected status.
  logic [4:0] exp_q[$];
  int m_level;
  bit m_ack;
  int m_cnt;
  bit m_err_oh;
  bit m_err_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_level  = 0;
    m_ack    = 1'b0;
    m_cnt    = 0;
    m_err_oh = 1'b0;
    m_err_id = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ack"},       32'(bus.ack),       32'(m_ack));
    check({tag, "_level"},     32'(fifo_level),    32'(m_level));
    check({tag, "_valid"},     32'(bus.out_valid), 32'(m_level != 0));
    check({tag, "_cnt"},       32'(grant_cnt),     32'(m_cnt));
    check({tag, "_err_oh"},    32'(err_onehot),    32'(m_err_oh));
    check({tag, "_err_id"},    32'(err_id_mis),    32'(m_err_id));
  endtask

  // One clock: drive inputs, predict the effect of the coming edge, then check.
  task automatic step(input logic [31:0] gw, input logic [4:0] gid, input bit rdy,
                      output bit cap);
    bit pop;
    bit push;
    bus.gnt_w     = gw;
    bus.gnt_id    = gid;
    bus.out_ready = rdy;
    pop  = (m_level != 0) && rdy;
    cap  = !m_ack && (gw != 32'd0) && ((m_level < DEPTH) || pop);
    push = 1'b0;
    if (cap) begin
      if ($countones(gw) != 1) begin
        m_err_oh = 1'b1;
      end else if (idx_of(gw) != int'(gid)) begin
        m_err_id = 1'b1;
      end else begin
        push = 1'b1;
        exp_q.push_back(gid);
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end
    m_level = m_level + int'(push) - int'(pop);
    m_ack   = cap;
    @(posedge clk);
    #1;
    check_status("step");
  endtask

  task automatic offer(input logic [31:0] gw, input logic [4:0] gid, input bit rdy,
                       input int max_cyc, output bit got);
    bit c;
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step(gw, gid, rdy, c);
      if (c) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    bit c;
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      step(32'd0, 5'd0, 1'b1, c);
    end
  endtask

  task automatic reset_now(input string tag);
    bus.gnt_w     = '0;
    bus.gnt_id    = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status(tag);
    check({tag, "_out_id"}, 32'(bus.out_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: head must match the model queue; a pop retires it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected actual=%0d required=none", bus.out_id);
        end else begin
          check("mon_head", 32'(bus.out_id), 32'(exp_q[0]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bit c;
    bit got;
    logic [31:0] cur_gw;
    logic [4:0]  cur_id;
    bit have;
    int ix;
    int r;
    logic [4:0] fill_ids [4];

    bus.gnt_w     = '0;
    bus.gnt_id    = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_status("reset");
    check("reset_out_id", 32'(bus.out_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single grant: ack only in the following cycle, entry visible immediately.
    step(32'h0000_0100, 5'd8, 1'b0, c);
    check("single_out_id", 32'(bus.out_id), 32'd8);
    step(32'd0, 5'd0, 1'b0, c);
    drain();

    // Fill then stall the fifth grant until one consumer pulse.
    for (int i = 0; i < 4; i++) begin
      offer(32'd1 << (i + 1), 5'(i + 1), 1'b0, 4, got);
    end
    offer(32'h0000_0040, 5'd6, 1'b0, 4, got);
    step(32'h0000_0040, 5'd6, 1'b1, c);
    step(32'd0, 5'd0, 1'b0, c);
    drain();

    // Full with simultaneous push/pop; order checked by the monitor.
    fill_ids[0] = 5'd3; fill_ids[1] = 5'd7; fill_ids[2] = 5'd12; fill_ids[3] = 5'd31;
    for (int i = 0; i < 4; i++) begin
      offer(32'd1 << fill_ids[i], fill_ids[i], 1'b0, 4, got);
    end
    step(32'd0, 5'd0, 1'b0, c);
    offer(32'h0000_0200, 5'd9, 1'b1, 4, got);
    offer(32'h0000_0004, 5'd2, 1'b1, 4, got);
    drain();

    // Integrity errors: acked, not queued, sticky.
    offer(32'h0000_0003, 5'd0, 1'b0, 3, got);
    step(32'd0, 5'd0, 1'b0, c);
    offer(32'h0000_0010, 5'd3, 1'b0, 3, got);
    step(32'd0, 5'd0, 1'b0, c);
    offer(32'h0000_0020, 5'd5, 1'b1, 3, got);
    drain();

    // Reset in the middle of an ack cycle.
    offer(32'h0000_0800, 5'd11, 1'b0, 3, got);
    reset_now("midack_reset");

    // Counter wrap: 17 good grants with the consumer always ready.
    for (int i = 0; i < 17; i++) begin
      offer(32'd1 << (i % 32), 5'(i % 32), 1'b1, 6, got);
    end
    check("wrap_cnt", 32'(grant_cnt), 32'd1);
    drain();

    // Randomized traffic, with occasional malformed grants.
    have = 1'b0;
    cur_gw = '0;
    cur_id = '0;
    for (int n = 0; n < 600; n++) begin
      if (!have && ($urandom % 3 != 0)) begin
        ix = int'($urandom % 32);
        r  = int'($urandom % 20);
        cur_gw = 32'd1 << ix;
        cur_id = 5'(ix);
        if (r == 0) begin
          cur_gw = cur_gw | (32'd1 << ((ix + 1) % 32));
        end else if (r == 1) begin
          cur_id = cur_id ^ 5'd1;
        end
        have = 1'b1;
      end
      if (have) begin
        step(cur_gw, cur_id, ($urandom % 4) != 0, c);
        if (c) have = 1'b0;
      end else begin
        step(32'd0, 5'd0, ($urandom % 4) != 0, c);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
